// File: rtl/mem_pkg.sv
// Shared main-memory block-interface types and arbiter state encoding used by
// the cache controllers, main memory and the memory-port arbiter.
package mem_pkg;

   localparam int BLOCKSIZE = 128;

   typedef struct packed {
      logic                 Valid;
      logic                 Wen;
      logic [31:0]          Addr;
      logic [BLOCKSIZE-1:0] WriteD;
   } MInput;

   typedef struct packed {
      logic                 Ready;
      logic [BLOCKSIZE-1:0] ReadD;
   } MOutput;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GNT_I,
      ARB_GNT_D
   } arb_state;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   // Owner vector is {D,I}, all-zero while no transaction is granted.
   function automatic logic [1:0] grantVector(input arb_state state);
      logic [1:0] vec;
      vec = 2'b00;
      if (state == ARB_GNT_I) vec = 2'b01;
      if (state == ARB_GNT_D) vec = 2'b10;
      return vec;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin owner of the single main-memory port shared by the I-cache and
// D-cache miss paths, with a sticky watchdog for a port that never answers.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  MInput      icache_req_i,
   output MOutput     icache_rsp_o,
   input  MInput      dcache_req_i,
   output MOutput     dcache_rsp_o,
   output MInput      mem_req_o,
   input  MOutput     mem_rsp_i,
   output logic [1:0] grant_o,
   output logic       err_timeout_o
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] WDOG_MAX = CNT_W'(TIMEOUT_CYCLES);

   arb_state         state_q, state_d;
   logic             lastGrant_q, lastGrant_d;
   logic [CNT_W-1:0] wdog_q, wdog_d;
   logic             errTimeout_q, errTimeout_d;
   MInput            ownerReq;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         lastGrant_q  <= OWNER_D;
         wdog_q       <= '0;
         errTimeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lastGrant_q  <= lastGrant_d;
         wdog_q       <= wdog_d;
         errTimeout_q <= errTimeout_d;
      end
   end

   // A completion or an owner abort both return to IDLE, which guarantees memory
   // sees Valid low for at least one cycle between transactions.
   always_comb begin
      state_d      = state_q;
      lastGrant_d  = lastGrant_q;
      wdog_d       = wdog_q;
      errTimeout_d = errTimeout_q;
      ownerReq     = '0;
      mem_req_o    = '0;
      icache_rsp_o = '0;
      dcache_rsp_o = '0;
      grant_o      = grantVector(state_q);

      unique case (state_q)
         ARB_IDLE: begin
            if (icache_req_i.Valid && (!dcache_req_i.Valid || lastGrant_q == OWNER_D)) begin
               state_d = ARB_GNT_I;
               wdog_d  = '0;
            end else if (dcache_req_i.Valid) begin
               state_d = ARB_GNT_D;
               wdog_d  = '0;
            end
         end
         ARB_GNT_I, ARB_GNT_D: begin
            if (state_q == ARB_GNT_I) begin
               ownerReq     = icache_req_i;
               icache_rsp_o = mem_rsp_i;
            end else begin
               ownerReq     = dcache_req_i;
               dcache_rsp_o = mem_rsp_i;
            end
            mem_req_o = ownerReq;
            if (mem_rsp_i.Ready || !ownerReq.Valid) begin
               state_d     = ARB_IDLE;
               lastGrant_d = (state_q == ARB_GNT_I) ? OWNER_I : OWNER_D;
            end else if (wdog_q != WDOG_MAX) begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      if (wdog_d == WDOG_MAX) errTimeout_d = 1'b1;
   end

   assign err_timeout_o = errTimeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: cache agents, a latency-programmable memory
// model and a negedge monitor comparing grants and responses against expectations.
module tb_mem_arbiter;
   import mem_pkg::*;

   typedef struct {
      logic  owner;
      MInput req;
      logic  aborts;
   } expT;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   MInput      icache_req_i = '0;
   MInput      dcache_req_i = '0;
   MOutput     icache_rsp_o, dcache_rsp_o;
   MInput      mem_req_o;
   MOutput     mem_rsp_i = '0;
   logic [1:0] grant_o;
   logic       err_timeout_o;

   int checks = 0;
   int errors = 0;

   MInput iQ[$];
   MInput dQ[$];
   expT   expQ[$];
   expT   respQ[$];
   logic  iDone = 0, dDone = 0, iAbort = 0, dAbort = 0;
   logic  deadPending = 0, prevValid = 0;
   logic  memEnable = 1;
   int    memLatency = 3;
   int    memWait = 0;

   mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .icache_req_i(icache_req_i), .icache_rsp_o(icache_rsp_o),
      .dcache_req_i(dcache_req_i), .dcache_rsp_o(dcache_rsp_o),
      .mem_req_o(mem_req_o), .mem_rsp_i(mem_rsp_i),
      .grant_o(grant_o), .err_timeout_o(err_timeout_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL globalTimeout observed=running required=finished");
      $fatal(1, "[TB] simulation time limit");
   end

   function automatic logic [BLOCKSIZE-1:0] dataFor(input logic [31:0] addr);
      return {addr, ~addr, 32'hA5A5_A5A5, addr ^ 32'h5A5A_5A5A};
   endfunction

   function automatic MInput mkReq(input logic wen, input logic [31:0] addr, input logic [BLOCKSIZE-1:0] wd);
      MInput r;
      r.Valid  = 1'b1;
      r.Wen    = wen;
      r.Addr   = addr;
      r.WriteD = wd;
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Queue a request on one cache side and record what memory must see for it.
   task automatic applyStimulus(input logic owner, input MInput req, input logic aborts);
      expT e;
      e.owner  = owner;
      e.req    = req;
      e.aborts = aborts;
      if (owner == OWNER_I) iQ.push_back(req);
      else dQ.push_back(req);
      expQ.push_back(e);
   endtask

   task automatic waitDrain(input string tag, input int maxCycles);
      int n = 0;
      while ((expQ.size() != 0 || respQ.size() != 0 || iQ.size() != 0 || dQ.size() != 0) && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_drained"}, (n < maxCycles) ? 1 : 0, 1);
   endtask

   task automatic waitGrant(input string tag, input logic [1:0] g, input int maxCycles);
      int n = 0;
      while (grant_o !== g && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_granted"}, grant_o, g);
   endtask

   // Cache agents: retire the head request after its Ready (or an abort) and present the next one.
   always @(posedge clk) begin
      #1;
      if (iDone || iAbort) begin
         if (iQ.size() > 0) iQ.delete(0);
         iDone  = 0;
         iAbort = 0;
      end
      if (dDone || dAbort) begin
         if (dQ.size() > 0) dQ.delete(0);
         dDone  = 0;
         dAbort = 0;
      end
      icache_req_i = (iQ.size() > 0) ? iQ[0] : '0;
      dcache_req_i = (dQ.size() > 0) ? dQ[0] : '0;
   end

   // Memory model: answers a held request after memLatency cycles with a one-cycle Ready.
   always @(posedge clk) begin
      #2;
      mem_rsp_i = '0;
      if (mem_req_o.Valid && memEnable) begin
         memWait++;
         if (memWait >= memLatency) begin
            mem_rsp_i.Ready = 1'b1;
            mem_rsp_i.ReadD = dataFor(mem_req_o.Addr);
            memWait = 0;
         end
      end else begin
         memWait = 0;
      end
   end

   always @(negedge clk) begin
      expT e;
      if (!rst) begin
         if (deadPending) begin
            checkOutput("deadCycleValid", mem_req_o.Valid, 0);
            checkOutput("deadCycleGrant", grant_o, 0);
            deadPending = 0;
         end
         if (mem_req_o.Valid && !prevValid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedGrant", grant_o, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("grant", grant_o, (e.owner == OWNER_D) ? 2'b10 : 2'b01);
               checkOutput("memReq", mem_req_o, e.req);
               if (!e.aborts) respQ.push_back(e);
            end
         end
         if (icache_rsp_o.Ready || dcache_rsp_o.Ready) begin
            if (respQ.size() == 0) begin
               checkOutput("unexpectedReady", {dcache_rsp_o.Ready, icache_rsp_o.Ready}, 0);
            end else begin
               e = respQ.pop_front();
               checkOutput("rspOwner", {dcache_rsp_o.Ready, icache_rsp_o.Ready},
                           (e.owner == OWNER_D) ? 2'b10 : 2'b01);
               if (e.owner == OWNER_I) begin
                  checkOutput("iReadD", icache_rsp_o.ReadD, dataFor(e.req.Addr));
                  checkOutput("dRspQuiet", dcache_rsp_o, 0);
               end else begin
                  checkOutput("dReadD", dcache_rsp_o.ReadD, dataFor(e.req.Addr));
                  checkOutput("iRspQuiet", icache_rsp_o, 0);
               end
            end
            if (icache_rsp_o.Ready) iDone = 1;
            if (dcache_rsp_o.Ready) dDone = 1;
            deadPending = 1;
         end
      end
      prevValid = mem_req_o.Valid;
   end

   initial begin
      // Reset held with both caches requesting; I must win the first tie afterwards.
      applyStimulus(OWNER_I, mkReq(1'b0, 32'h0000_0100, '0), 1'b0);
      applyStimulus(OWNER_D, mkReq(1'b0, 32'h0000_0200, '0), 1'b0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("rstGrant", grant_o, 0);
         checkOutput("rstMemValid", mem_req_o.Valid, 0);
         checkOutput("rstErr", err_timeout_o, 0);
      end
      rst = 1'b0;
      @(negedge clk);
      checkOutput("firstGrantI", grant_o, 2'b01);
      waitDrain("reset", 60);

      // Four back-to-back transactions with both sides busy alternate I,D,I,D.
      applyStimulus(OWNER_I, mkReq(1'b0, 32'h0000_0300, '0), 1'b0);
      applyStimulus(OWNER_D, mkReq(1'b0, 32'h0000_0400, '0), 1'b0);
      applyStimulus(OWNER_I, mkReq(1'b0, 32'h0000_0500, '0), 1'b0);
      applyStimulus(OWNER_D, mkReq(1'b0, 32'h0000_0600, '0), 1'b0);
      waitDrain("roundRobin", 100);

      // Single I read, memory answers on the third granted cycle.
      applyStimulus(OWNER_I, mkReq(1'b0, 32'h0000_0080, '0), 1'b0);
      waitDrain("singleRead", 40);
      checkOutput("idleAfterRead", grant_o, 0);

      // D write-back first, I arrives while D owns the port.
      memLatency = 4;
      applyStimulus(OWNER_D, mkReq(1'b1, 32'h0000_1040, {BLOCKSIZE{1'b1}}), 1'b0);
      repeat (2) @(negedge clk);
      applyStimulus(OWNER_I, mkReq(1'b0, 32'h0000_2000, '0), 1'b0);
      @(negedge clk);
      checkOutput("wbStillD", grant_o, 2'b10);
      waitDrain("writeBack", 60);

      // I drops Valid mid-transaction; pending D must be granted after one idle cycle.
      memLatency = 6;
      applyStimulus(OWNER_I, mkReq(1'b0, 32'h0000_3000, '0), 1'b1);
      waitGrant("abortI", 2'b01, 20);
      applyStimulus(OWNER_D, mkReq(1'b0, 32'h0000_4000, '0), 1'b0);
      @(negedge clk);
      iAbort = 1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("abortIdle", grant_o, 0);
      @(negedge clk);
      checkOutput("abortNextD", grant_o, 2'b10);
      waitDrain("abort", 60);

      // Memory never answers: err rises on the ninth granted cycle and is sticky.
      memEnable = 0;
      applyStimulus(OWNER_I, mkReq(1'b0, 32'h0000_5000, '0), 1'b1);
      waitGrant("wdog", 2'b01, 20);
      for (int c = 1; c <= 8; c++) begin
         if (c == 1 || c == 8) checkOutput("errLowEarly", err_timeout_o, 0);
         @(negedge clk);
      end
      checkOutput("errNinth", err_timeout_o, 1);
      repeat (4) @(negedge clk);
      checkOutput("errSticky", err_timeout_o, 1);
      checkOutput("wdogNoAbort", grant_o, 2'b01);
      iAbort = 1;
      repeat (3) @(negedge clk);
      checkOutput("errStickyIdle", err_timeout_o, 1);
      waitDrain("wdog", 10);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("errCleared", err_timeout_o, 0);
      rst = 1'b0;
      memEnable = 1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
